// File: rtl/alu_iter_exec.sv
// Execute-stage ALU behind a valid/ready handshake. Shifts and rotates run one
// bit per cycle in a work register; every other op finishes at the accept edge.
module alu_iter_exec #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             invA,
  input  logic             invB,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ofl,
  output logic             err
);

  localparam logic [3:0] OP_RLL  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SRA  = 4'b0010;
  localparam logic [3:0] OP_SRL  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SLBI = 4'b1000;
  localparam logic [3:0] OP_BTR  = 4'b1001;
  localparam logic [3:0] OP_RRL  = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_ofl;
  logic               r_err;
  logic               r_out_valid;
  logic [SHAMT_W-1:0] r_count;
  logic [WIDTH-1:0]   r_work;
  logic [3:0]         r_op;

  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_btr;
  logic [WIDTH-1:0]   w_res;
  logic [WIDTH-1:0]   w_step;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_is_shift;
  logic               w_illegal;
  logic               w_ofl;

  assign w_a     = invA ? ~A : A;
  assign w_b     = invB ? ~B : B;
  // Shift amount always comes from the raw B operand, ignoring invB.
  assign w_shamt = B[SHAMT_W-1:0];
  assign w_sum   = w_a + w_b + {{(WIDTH-1){1'b0}}, cin};

  assign w_is_shift = (aluOp == OP_RLL) || (aluOp == OP_SLL) || (aluOp == OP_SRA) ||
                      (aluOp == OP_SRL) || (aluOp == OP_RRL);
  assign w_illegal  = (aluOp > OP_RRL);
  assign w_ofl      = (aluOp == OP_ADD) && (w_a[WIDTH-1] == w_b[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != w_a[WIDTH-1]);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_btr
      assign w_btr[gi] = w_a[WIDTH-1-gi];
    end
  endgenerate

  // Single-cycle result; shift ops only land here when the amount is zero.
  always_comb begin
    w_res = '0;
    case (aluOp)
      OP_RLL, OP_SLL, OP_SRA, OP_SRL, OP_RRL: w_res = w_a;
      OP_ADD:  w_res = w_sum;
      OP_AND:  w_res = w_a & w_b;
      OP_OR:   w_res = w_a | w_b;
      OP_XOR:  w_res = w_a ^ w_b;
      OP_SLBI: w_res = {w_a[WIDTH-9:0], w_b[7:0]};
      OP_BTR:  w_res = w_btr;
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_step = r_work;
    case (r_op)
      OP_RLL:  w_step = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
      OP_RRL:  w_step = {r_work[0], r_work[WIDTH-1:1]};
      OP_SLL:  w_step = {r_work[WIDTH-2:0], 1'b0};
      OP_SRL:  w_step = {1'b0, r_work[WIDTH-1:1]};
      OP_SRA:  w_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      default: w_step = r_work;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_ofl       <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_count     <= '0;
      r_work      <= '0;
      r_op        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op  <= aluOp;
            r_err <= w_illegal;
            if (w_is_shift && (w_shamt != '0)) begin
              r_work  <= w_a;
              r_count <= w_shamt;
              r_ofl   <= 1'b0;
              r_state <= S_SHIFT;
            end else begin
              r_result    <= w_res;
              r_zero      <= (w_res == '0);
              r_ofl       <= w_ofl;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          r_work  <= w_step;
          r_count <= r_count - SHAMT_W'(1);
          if (r_count == SHAMT_W'(1)) begin
            r_result    <= w_step;
            r_zero      <= (w_step == '0);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) & ~rst;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign ofl       = r_ofl;
  assign err       = r_err;

endmodule
